// File: rtl/cprv_mem_stage.sv
// Memory-access stage: single-outstanding req/gnt/rvalid data bus, load align/extend,
// and a one-entry registered result toward write-back.
module cprv_mem_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_mem_i,
    output logic                    ready_mem_o,
    input  logic [DATA_WIDTH-1:0]   alu_out_mem_i,
    input  logic [DATA_WIDTH-1:0]   rs2_data_mem_i,
    input  logic [4:0]              rd_addr_mem_i,
    input  logic                    rd_en_mem_i,
    input  logic [6:0]              opcode_mem_i,
    input  logic [2:0]              funct3_mem_i,
    input  logic                    mem_w_en_mem_i,
    output logic                    dmem_req_o,
    input  logic                    dmem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic                    dmem_we_o,
    output logic [DATA_WIDTH/8-1:0] dmem_be_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    input  logic                    dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
    output logic                    valid_wb_o,
    input  logic                    ready_wb_i,
    output logic [4:0]              rd_addr_wb_o,
    output logic                    rd_en_wb_o,
    output logic [DATA_WIDTH-1:0]   rd_data_wb_o,
    output logic                    misalign_wb_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
    state_t state, state_nxt;

    logic                  out_free, accept, is_mem, misalign, start_mem;
    logic [OFF_W-1:0]      off, off_q;
    logic [2:0]            funct3_q;
    logic [4:0]            rd_addr_q;
    logic                  rd_en_q;
    logic [BE_W-1:0]       size_mask;
    logic [DATA_WIDTH-1:0] shifted, load_data;
    logic                  res_vld, res_rd_en, res_mis;
    logic [4:0]            res_rd_addr;
    logic [DATA_WIDTH-1:0] res_data;

    assign out_free    = !valid_wb_o || ready_wb_i;
    assign ready_mem_o = (state == IDLE) && out_free;
    assign accept      = valid_mem_i && ready_mem_o;
    assign is_mem      = (opcode_mem_i == OP_LOAD) || (opcode_mem_i == OP_STORE);
    assign off         = alu_out_mem_i[OFF_W-1:0];
    assign start_mem   = accept && is_mem && !misalign;

    always_comb begin
        misalign = 1'b0;
        if (is_mem) begin
            case (funct3_mem_i[1:0])
                2'b01:   misalign = off[0];
                2'b10:   misalign = |off[1:0];
                2'b11:   misalign = |off;
                default: misalign = 1'b0;
            endcase
        end
    end

    always_comb begin
        size_mask = '0;
        case (funct3_mem_i[1:0])
            2'b00:   size_mask[0]   = 1'b1;
            2'b01:   size_mask[1:0] = '1;
            2'b10:   size_mask[3:0] = '1;
            default: size_mask      = '1;
        endcase
    end

    // Read data is a full aligned doubleword; bring the addressed bytes down to bit 0.
    always_comb begin
        shifted = dmem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            3'b110:  load_data = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mem) state_nxt = REQ;
            REQ:     if (dmem_gnt_i) state_nxt = dmem_we_o ? IDLE : WAIT_R;
            WAIT_R:  if (dmem_rvalid_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // At most one result source fires per cycle; memory results only arrive
    // while the output register is already empty.
    always_comb begin
        res_vld     = 1'b0;
        res_data    = '0;
        res_rd_addr = rd_addr_q;
        res_rd_en   = 1'b0;
        res_mis     = 1'b0;
        if (accept && (!is_mem || misalign)) begin
            res_vld     = 1'b1;
            res_data    = alu_out_mem_i;
            res_rd_addr = rd_addr_mem_i;
            res_rd_en   = rd_en_mem_i && !misalign;
            res_mis     = misalign;
        end else if (state == REQ && dmem_gnt_i && dmem_we_o) begin
            res_vld = 1'b1;
        end else if (state == WAIT_R && dmem_rvalid_i) begin
            res_vld   = 1'b1;
            res_data  = load_data;
            res_rd_en = rd_en_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q        <= '0;
            funct3_q     <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
        end else if (start_mem) begin
            off_q        <= off;
            funct3_q     <= funct3_mem_i;
            rd_addr_q    <= rd_addr_mem_i;
            rd_en_q      <= rd_en_mem_i;
            dmem_req_o   <= 1'b1;
            dmem_addr_o  <= {alu_out_mem_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            dmem_we_o    <= mem_w_en_mem_i;
            dmem_be_o    <= mem_w_en_mem_i ? (size_mask << off) : '1;
            dmem_wdata_o <= mem_w_en_mem_i ? (rs2_data_mem_i << {off, 3'b000}) : '0;
        end else if (state == REQ && dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_wb_o    <= 1'b0;
            rd_addr_wb_o  <= '0;
            rd_en_wb_o    <= 1'b0;
            rd_data_wb_o  <= '0;
            misalign_wb_o <= 1'b0;
        end else if (res_vld) begin
            valid_wb_o    <= 1'b1;
            rd_addr_wb_o  <= res_rd_addr;
            rd_en_wb_o    <= res_rd_en;
            rd_data_wb_o  <= res_data;
            misalign_wb_o <= res_mis;
        end else if (ready_wb_i) begin
            valid_wb_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cprv_mem_stage.sv
// Directed bench for cprv_mem_stage: a vector table of single transactions plus
// hand-written sequences for back-to-back, reset abandonment and back-pressure.
module tb_cprv_mem_stage;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_mem_i = 1'b0;
    logic        ready_mem_o;
    logic [63:0] alu_out_mem_i = '0;
    logic [63:0] rs2_data_mem_i = '0;
    logic [4:0]  rd_addr_mem_i = '0;
    logic        rd_en_mem_i = 1'b0;
    logic [6:0]  opcode_mem_i = '0;
    logic [2:0]  funct3_mem_i = '0;
    logic        mem_w_en_mem_i = 1'b0;
    logic        dmem_req_o;
    logic        dmem_gnt_i = 1'b0;
    logic [63:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [7:0]  dmem_be_o;
    logic [63:0] dmem_wdata_o;
    logic        dmem_rvalid_i = 1'b0;
    logic [63:0] dmem_rdata_i = '0;
    logic        valid_wb_o;
    logic        ready_wb_i = 1'b1;
    logic [4:0]  rd_addr_wb_o;
    logic        rd_en_wb_o;
    logic [63:0] rd_data_wb_o;
    logic        misalign_wb_o;

    int tests = 0;
    int fails = 0;

    cprv_mem_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o),
        .alu_out_mem_i(alu_out_mem_i), .rs2_data_mem_i(rs2_data_mem_i),
        .rd_addr_mem_i(rd_addr_mem_i), .rd_en_mem_i(rd_en_mem_i),
        .opcode_mem_i(opcode_mem_i), .funct3_mem_i(funct3_mem_i),
        .mem_w_en_mem_i(mem_w_en_mem_i),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
        .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
        .rd_addr_wb_o(rd_addr_wb_o), .rd_en_wb_o(rd_en_wb_o),
        .rd_data_wb_o(rd_data_wb_o), .misalign_wb_o(misalign_wb_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        we;
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        rd_en;
        logic [3:0]  gnt_dly;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_data;
        logic        chk_data;
        logic        exp_rd_en;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic we,
                            input logic [63:0] alu, input logic [63:0] rs2,
                            input logic [4:0] rd, input logic rd_en);
        valid_mem_i    = 1'b1;
        opcode_mem_i   = op;
        funct3_mem_i   = f3;
        mem_w_en_mem_i = we;
        alu_out_mem_i  = alu;
        rs2_data_mem_i = rs2;
        rd_addr_mem_i  = rd;
        rd_en_mem_i    = rd_en;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        ready_wb_i = 1'b1;
        drive_op(v.op, v.f3, v.we, v.alu, v.rs2, v.rd, v.rd_en);
        #1;
        check($sformatf("v%0d ready_mem", idx), 64'(ready_mem_o), 64'd1);
        tick();
        valid_mem_i = 1'b0;
        if (v.exp_req) begin
            for (int i = 0; i <= int'(v.gnt_dly); i++) begin
                check($sformatf("v%0d req c%0d", idx, i), 64'(dmem_req_o), 64'd1);
                check($sformatf("v%0d addr c%0d", idx, i), dmem_addr_o, v.exp_addr);
                check($sformatf("v%0d be c%0d", idx, i), 64'(dmem_be_o), 64'(v.exp_be));
                check($sformatf("v%0d we c%0d", idx, i), 64'(dmem_we_o), 64'(v.we));
                if (v.we) check($sformatf("v%0d wdata c%0d", idx, i), dmem_wdata_o, v.exp_wdata);
                if (i == int'(v.gnt_dly)) dmem_gnt_i = 1'b1;
                tick();
            end
            dmem_gnt_i = 1'b0;
            check($sformatf("v%0d req drop", idx), 64'(dmem_req_o), 64'd0);
            if (!v.we) begin
                check($sformatf("v%0d no early result", idx), 64'(valid_wb_o), 64'd0);
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = v.rdata;
                tick();
                dmem_rvalid_i = 1'b0;
            end
        end else begin
            check($sformatf("v%0d no req", idx), 64'(dmem_req_o), 64'd0);
        end
        check($sformatf("v%0d valid_wb", idx), 64'(valid_wb_o), 64'd1);
        check($sformatf("v%0d rd_addr", idx), 64'(rd_addr_wb_o), 64'(v.rd));
        check($sformatf("v%0d rd_en", idx), 64'(rd_en_wb_o), 64'(v.exp_rd_en));
        check($sformatf("v%0d misalign", idx), 64'(misalign_wb_o), 64'(v.exp_mis));
        if (v.chk_data) check($sformatf("v%0d rd_data", idx), rd_data_wb_o, v.exp_data);
        tick();
        check($sformatf("v%0d drained", idx), 64'(valid_wb_o), 64'd0);
    endtask

    initial begin
        //          op     f3      we    alu                   rs2                     rdata                  rd     en  dly  req  addr          be     wdata                   data                   chk en  mis
        vecs[0]  = '{OP_ALU, 3'b000, 1'b0, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 4'd0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h1234, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{OP_LD,  3'b000, 1'b0, 64'h1003, 64'h0, 64'h00000000_80FF0000, 5'd7, 1'b1, 4'd2, 1'b1, 64'h1000, 8'hFF, 64'h0, 64'hFFFFFFFF_FFFFFF80, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{OP_LD,  3'b100, 1'b0, 64'h1003, 64'h0, 64'h00000000_80FF0000, 5'd8, 1'b1, 4'd1, 1'b1, 64'h1000, 8'hFF, 64'h0, 64'h80, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{OP_ST,  3'b001, 1'b1, 64'h2006, 64'hABCD, 64'h0, 5'd0, 1'b0, 4'd0, 1'b1, 64'h2000, 8'hC0, 64'hABCD0000_00000000, 64'h0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_LD,  3'b010, 1'b0, 64'h3002, 64'h0, 64'h0, 5'd9, 1'b1, 4'd0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h3002, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{OP_LD,  3'b001, 1'b0, 64'h1006, 64'h0, 64'h80010000_00000000, 5'd10, 1'b1, 4'd0, 1'b1, 64'h1000, 8'hFF, 64'h0, 64'hFFFFFFFF_FFFF8001, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{OP_LD,  3'b110, 1'b0, 64'h4004, 64'h0, 64'h89ABCDEF_00000000, 5'd11, 1'b1, 4'd0, 1'b1, 64'h4000, 8'hFF, 64'h0, 64'h00000000_89ABCDEF, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{OP_LD,  3'b011, 1'b0, 64'h5000, 64'h0, 64'h01234567_89ABCDEF, 5'd12, 1'b1, 4'd1, 1'b1, 64'h5000, 8'hFF, 64'h0, 64'h01234567_89ABCDEF, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{OP_LD,  3'b111, 1'b0, 64'h5008, 64'h0, 64'hFEDCBA98_76543210, 5'd13, 1'b1, 4'd0, 1'b1, 64'h5008, 8'hFF, 64'h0, 64'hFEDCBA98_76543210, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{OP_ST,  3'b011, 1'b1, 64'h6004, 64'h55, 64'h0, 5'd0, 1'b0, 4'd0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h6004, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{OP_ST,  3'b000, 1'b1, 64'h7005, 64'h11223344_556677AA, 64'h0, 5'd0, 1'b0, 4'd3, 1'b1, 64'h7000, 8'h20, 64'h6677AA00_00000000, 64'h0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_LD,  3'b010, 1'b0, 64'h3004, 64'h0, 64'h80000000_12345678, 5'd14, 1'b1, 4'd0, 1'b1, 64'h3000, 8'hFF, 64'h0, 64'hFFFFFFFF_80000000, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{OP_ST,  3'b010, 1'b1, 64'h2004, 64'hDEADBEEF, 64'h0, 5'd0, 1'b0, 4'd0, 1'b1, 64'h2000, 8'hF0, 64'hDEADBEEF_00000000, 64'h0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_LD,  3'b101, 1'b0, 64'h1001, 64'h0, 64'h0, 5'd15, 1'b1, 4'd0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h1001, 1'b1, 1'b0, 1'b1};

        // reset state
        #12;
        check("rst valid_wb", 64'(valid_wb_o), 64'd0);
        check("rst req", 64'(dmem_req_o), 64'd0);
        check("rst we", 64'(dmem_we_o), 64'd0);
        check("rst be", 64'(dmem_be_o), 64'd0);
        check("rst addr", dmem_addr_o, 64'd0);
        check("rst wdata", dmem_wdata_o, 64'd0);
        check("rst rd_data", rd_data_wb_o, 64'd0);
        check("rst rd_en", 64'(rd_en_wb_o), 64'd0);
        check("rst misalign", 64'(misalign_wb_o), 64'd0);
        check("rst ready_mem", 64'(ready_mem_o), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) run_vec(i);

        // three back-to-back ALU ops, one result per cycle
        drive_op(OP_ALU, 3'b001, 1'b0, 64'h1234, 64'h0, 5'd5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) valid_mem_i = 1'b0;
            check($sformatf("b2b%0d valid", k), 64'(valid_wb_o), 64'd1);
            check($sformatf("b2b%0d data", k), rd_data_wb_o, 64'h1234);
            check($sformatf("b2b%0d rd", k), 64'(rd_addr_wb_o), 64'd5);
            check($sformatf("b2b%0d misalign", k), 64'(misalign_wb_o), 64'd0);
            check($sformatf("b2b%0d ready_mem", k), 64'(ready_mem_o), 64'd1);
        end
        tick();

        // reset while a request is outstanding drops req without a clock edge
        drive_op(OP_LD, 3'b011, 1'b0, 64'h5000, 64'h0, 5'd3, 1'b1);
        tick();
        valid_mem_i = 1'b0;
        check("rreq req up", 64'(dmem_req_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rreq req async drop", 64'(dmem_req_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset mid WAIT_R, then a stale rvalid must be ignored
        drive_op(OP_LD, 3'b011, 1'b0, 64'h5000, 64'h0, 5'd3, 1'b1);
        tick();
        valid_mem_i = 1'b0;
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rwait req", 64'(dmem_req_o), 64'd0);
        check("rwait valid_wb", 64'(valid_wb_o), 64'd0);
        check("rwait ready_mem", 64'(ready_mem_o), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'hDEAD;
        tick();
        dmem_rvalid_i = 1'b0;
        check("rwait stale rvalid", 64'(valid_wb_o), 64'd0);
        check("rwait ready after", 64'(ready_mem_o), 64'd1);

        // load completes under back-pressure; result held, stage stalls
        drive_op(OP_LD, 3'b011, 1'b0, 64'h5000, 64'h0, 5'd20, 1'b1);
        tick();
        valid_mem_i = 1'b0;
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        ready_wb_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'h01234567_89ABCDEF;
        tick();
        dmem_rvalid_i = 1'b0;
        drive_op(OP_ALU, 3'b000, 1'b0, 64'h9999, 64'h0, 5'd21, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp%0d valid", k), 64'(valid_wb_o), 64'd1);
            check($sformatf("bp%0d data", k), rd_data_wb_o, 64'h01234567_89ABCDEF);
            check($sformatf("bp%0d rd", k), 64'(rd_addr_wb_o), 64'd20);
            check($sformatf("bp%0d ready_mem", k), 64'(ready_mem_o), 64'd0);
            tick();
        end
        ready_wb_i = 1'b1;
        #1;
        check("bp release ready_mem", 64'(ready_mem_o), 64'd1);
        tick();
        valid_mem_i = 1'b0;
        check("bp next valid", 64'(valid_wb_o), 64'd1);
        check("bp next data", rd_data_wb_o, 64'h9999);
        check("bp next rd", 64'(rd_addr_wb_o), 64'd21);
        tick();
        check("bp drained", 64'(valid_wb_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
